// File: rtl/sinc_polyphase_interp.sv
// Polyphase FIR interpolator: loads a FILTERS x TAPS coefficient bank, shifts samples into a
// TAPS-deep delay line and runs a serial MAC over the selected phase row to one saturated output.
module sinc_polyphase_interp #(
  parameter int FILTERS = 40,
  parameter int TAPS    = 6,
  parameter int DW      = 16,
  parameter int CW      = 18,
  parameter int OW      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         coef_we,
  input  logic [$clog2(FILTERS)-1:0]   coef_filter,
  input  logic [$clog2(TAPS)-1:0]      coef_tap,
  input  logic signed [CW-1:0]         coef_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DW-1:0]         in_data,
  input  logic [$clog2(FILTERS)-1:0]   in_phase,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OW-1:0]         out_data,
  output logic                         busy
);

  localparam int FW = $clog2(FILTERS);
  localparam int TW = $clog2(TAPS);
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + TW;

  localparam logic signed [AW-1:0] RND_C    = {{(AW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};
  localparam logic signed [AW-1:0] SAT_HI_C = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO_C = {{(AW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic signed [OW-1:0] OUT_HI_C = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OUT_LO_C = {1'b1, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic signed [DW-1:0]  d_r    [TAPS];
  logic signed [CW-1:0]  coef_r [FILTERS][TAPS];
  logic [FW-1:0]         phase_r;
  logic [TW-1:0]         tap_r;
  logic signed [AW-1:0]  acc_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  busy_r;
  logic signed [OW-1:0]  out_data_r;

  logic                  accept_s;
  logic                  coef_wr_s;
  logic [FW-1:0]         phase_s;
  logic signed [PW-1:0]  prod_s;
  logic signed [AW-1:0]  rnd_s;
  logic signed [AW-1:0]  shf_s;
  logic signed [OW-1:0]  sat_s;
  logic                  in_ready_s;
  logic                  out_valid_s;
  logic                  busy_s;

  assign accept_s  = (state_r == IDLE) && in_ready_r && in_valid;
  assign coef_wr_s = coef_we && (state_r == IDLE)
                     && ({1'b0, coef_filter} < (FW+1)'(FILTERS))
                     && ({1'b0, coef_tap} < (TW+1)'(TAPS));

  // Phase clamp, tap product and rounded/saturated result.
  always_comb begin
    if ({1'b0, in_phase} >= (FW+1)'(FILTERS)) begin
      phase_s = FW'(FILTERS - 1);
    end else begin
      phase_s = in_phase;
    end
    prod_s = PW'(d_r[tap_r]) * PW'(coef_r[phase_r][tap_r]);
    rnd_s  = acc_r + RND_C;
    shf_s  = rnd_s >>> (CW - 1);
    if (shf_s > SAT_HI_C) begin
      sat_s = OUT_HI_C;
    end else if (shf_s < SAT_LO_C) begin
      sat_s = OUT_LO_C;
    end else begin
      sat_s = shf_s[OW-1:0];
    end
  end

  // Coefficient bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < FILTERS; f++) begin
        for (int t = 0; t < TAPS; t++) begin
          coef_r[f][t] <= '0;
        end
      end
    end else if (coef_wr_s) begin
      coef_r[coef_filter][coef_tap] <= coef_data;
    end
  end

  // Delay line, latched phase and serial MAC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < TAPS; t++) begin
        d_r[t] <= '0;
      end
      phase_r <= '0;
      tap_r   <= '0;
      acc_r   <= '0;
    end else if (accept_s) begin
      for (int t = 0; t < TAPS - 1; t++) begin
        d_r[t] <= d_r[t+1];
      end
      d_r[TAPS-1] <= in_data;
      phase_r     <= phase_s;
      tap_r       <= '0;
      acc_r       <= '0;
    end else if (state_r == MAC) begin
      acc_r <= acc_r + AW'(prod_s);
      tap_r <= tap_r + TW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; OUT holds until a presented result is taken.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = MAC;
        else          next_state_s = IDLE;
      end
      MAC: begin
        if (tap_r == TW'(TAPS - 1)) next_state_s = OUT;
        else                        next_state_s = MAC;
      end
      OUT: begin
        if (out_valid_r && out_ready) next_state_s = IDLE;
        else                          next_state_s = OUT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode; the first OUT cycle registers the result before it is presented.
  always_comb begin
    in_ready_s  = (next_state_s == IDLE);
    busy_s      = (next_state_s != IDLE);
    out_valid_s = (state_r == OUT) && (next_state_s == OUT);
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      out_data_r  <= '0;
    end else begin
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      if ((state_r == OUT) && !out_valid_r) begin
        out_data_r <= sat_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_sinc_polyphase_interp.sv
// Self-checking bench: directed test-plan cases plus randomized traffic against a
// sum-of-products reference model with rounding and saturation.
module tb_sinc_polyphase_interp;
  localparam int FILTERS = 40;
  localparam int TAPS    = 6;
  localparam int DW      = 16;
  localparam int CW      = 18;
  localparam int OW      = 16;
  localparam int FW      = $clog2(FILTERS);
  localparam int TW      = $clog2(TAPS);

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 coef_we;
  logic [FW-1:0]        coef_filter;
  logic [TW-1:0]        coef_tap;
  logic signed [CW-1:0] coef_data;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [FW-1:0]        in_phase;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic                 busy;

  sinc_polyphase_interp #(.FILTERS(FILTERS), .TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
    .clk(clk), .reset(reset), .coef_we(coef_we), .coef_filter(coef_filter),
    .coef_tap(coef_tap), .coef_data(coef_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_phase(in_phase), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int val; int edge_n; } exp_t;
  exp_t exp_q[$];
  int   got_q[$];
  int   checks = 0;
  int   errors = 0;
  int   edges = 0;
  int   ready_mode = 0;
  int   c_m [FILTERS][TAPS];
  int   d_m [TAPS];
  logic vld_prev = 1'b0;
  int   dat_prev = 0;
  logic rdy_edge;
  exp_t e;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic check_out(input string name, input int idx, input int want);
    if (idx < got_q.size()) check(name, got_q[idx], want);
    else check(name, 32'h7fffffff, want);
  endtask

  task automatic model_clear();
    for (int f = 0; f < FILTERS; f++)
      for (int t = 0; t < TAPS; t++) c_m[f][t] = 0;
    for (int t = 0; t < TAPS; t++) d_m[t] = 0;
  endtask

  task automatic model_write(input int f, input int t, input int v);
    if (f < FILTERS && t < TAPS) c_m[f][t] = v;
  endtask

  // y = sat(floor((sum d*C + 2^(CW-2)) / 2^(CW-1)))
  function automatic int model_result(input int ph);
    longint s = 0;
    int p = (ph >= FILTERS) ? FILTERS - 1 : ph;
    for (int t = 0; t < TAPS; t++) s += longint'(d_m[t]) * longint'(c_m[p][t]);
    s = (s + (64'sd1 <<< (CW - 2))) >>> (CW - 1);
    if (s > 64'sd32767) return 32767;
    if (s < -64'sd32768) return -32768;
    return int'(s);
  endfunction

  // Output ready pattern driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 1) == 1);
      else out_ready = 1'b0;
    end
  end

  // Compare process: checks every cycle's outputs against the model's expectation queue.
  always @(posedge clk) begin
    rdy_edge = out_ready;
    edges++;
    #1;
    if (reset) begin
      vld_prev = 1'b0;
    end else begin
      check("ready_vs_busy", int'(in_ready), int'(!busy));
      if (out_valid && !vld_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(out_data), e.val);
          check("latency", edges - e.edge_n, TAPS + 1);
          got_q.push_back(int'(out_data));
        end
      end else if (vld_prev && !rdy_edge) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_data", int'(out_data), dat_prev);
      end else if (vld_prev && rdy_edge) begin
        check("post_hs_valid", int'(out_valid), 0);
        check("post_hs_ready", int'(in_ready), 1);
      end
      vld_prev = out_valid;
      dat_prev = int'(out_data);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input int f, input int t, input int v);
    coef_we = 1'b1;
    coef_filter = f[FW-1:0];
    coef_tap = t[TW-1:0];
    coef_data = v[CW-1:0];
    model_write(f, t, v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send(input int x, input int ph, input bit we, input int wf, input int wt, input int wv);
    int n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data = x[DW-1:0];
    in_phase = ph[FW-1:0];
    if (we) begin
      coef_we = 1'b1;
      coef_filter = wf[FW-1:0];
      coef_tap = wt[TW-1:0];
      coef_data = wv[CW-1:0];
      model_write(wf, wt, wv);
    end
    for (int t = 0; t < TAPS - 1; t++) d_m[t] = d_m[t+1];
    d_m[TAPS-1] = x;
    exp_q.push_back('{model_result(ph), edges + 1});
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic send0(input int x, input int ph);
    send(x, ph, 1'b0, 0, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int n;
    coef_we = 1'b0; coef_filter = '0; coef_tap = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; in_phase = '0;
    model_clear();

    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_in_ready", int'(in_ready), 1);

    // Unit impulse
    do_reset();
    wr(3, 5, 65536);
    got_q.delete();
    send0(1000, 3);
    drain();
    check_out("impulse", 0, 500);

    // Delay-line ordering
    do_reset();
    wr(0, 0, 65536);
    got_q.delete();
    for (int i = 1; i <= 7; i++) send0(10 * i, 0);
    drain();
    check_out("order0", 0, 0);
    check_out("order4", 4, 0);
    check_out("order5", 5, 5);
    check_out("order6", 6, 10);

    // Saturation
    do_reset();
    for (int t = 0; t < TAPS; t++) wr(1, t, 131071);
    got_q.delete();
    for (int i = 0; i < 6; i++) send0(32767, 1);
    for (int i = 0; i < 6; i++) send0(-32768, 1);
    drain();
    check_out("sat_pos", 5, 32767);
    check_out("sat_neg", 11, -32768);

    // Backpressure with ignored input and coefficient write
    do_reset();
    wr(3, 5, 65536);
    got_q.delete();
    ready_mode = 2;
    send0(1000, 3);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reached_out", int'(out_valid), 1);
    in_valid = 1'b1; in_data = 16'sd777; in_phase = 6'd3;
    coef_we = 1'b1; coef_filter = 6'd3; coef_tap = 3'd5; coef_data = 18'sd12345;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_data", int'(out_data), 500);
    end
    in_valid = 1'b0;
    coef_we = 1'b0;
    ready_mode = 0;
    drain();
    send0(4000, 3);
    drain();
    check_out("bp_first", 0, 500);
    check_out("bp_coef_kept", 1, 2000);

    // Phase clamp
    do_reset();
    wr(39, 5, 65536);
    got_q.delete();
    send0(2000, 45);
    drain();
    check_out("clamp", 0, 1000);

    // Reset mid-MAC
    do_reset();
    for (int t = 0; t < TAPS; t++) wr(2, t, 65536);
    send0(1234, 2);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_ready", int'(in_ready), 0);
    exp_q.delete();
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_rel_ready", int'(in_ready), 1);
    got_q.delete();
    send0(555, 2);
    drain();
    check_out("mid_rst_zero", 0, 0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 60; i++)
      wr(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
         int'($urandom_range(0, 262143)) - 131072);
    ready_mode = 1;
    for (int i = 0; i < 120; i++) begin
      int x  = int'($urandom_range(0, 65535)) - 32768;
      int ph = int'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0)
        send(x, ph, 1'b1, int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 262143)) - 131072);
      else
        send0(x, ph);
    end
    drain();
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
